// File: rtl/div32_seq.sv
// Multi-cycle restoring divider: one trial subtraction per cycle, 32 cycles per result.
// Optional signed mode is enabled by defining DIV_SIGNED_EN (adds the is_signed port).
module div32_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, r_d, r_quot, r_rem;
  logic [WIDTH:0]   r_r;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dz;

  logic             w_accept, w_last, w_carry, w_unused_t_msb;
  logic [WIDTH:0]   w_s, w_r_nxt;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH-1:0] w_q_nxt, w_dvd_cap, w_dvs_cap, w_quot_fix, w_rem_fix;

  // start is only honoured outside RUN; a request during RUN is dropped.
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  // Trial subtraction S - {0,D} as S + ~{0,D} + 1; carry-out 1 means no borrow.
  assign w_s     = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_sum   = {1'b0, w_s} + {1'b0, ~{1'b0, r_d}} + (WIDTH+2)'(1);
  assign w_carry = w_sum[WIDTH+1];
  assign w_r_nxt = w_carry ? w_sum[WIDTH:0] : w_s;
  assign w_q_nxt = {r_q[WIDTH-2:0], w_carry};
  // The partial remainder stays below D, so the top bit of R never feeds back.
  assign w_unused_t_msb = r_r[WIDTH];

`ifdef DIV_SIGNED_EN
  logic r_neg_q, r_neg_r;
  logic w_neg_q_cap, w_neg_r_cap;

  assign w_neg_r_cap = is_signed && dividend[WIDTH-1];
  // Divide by zero keeps the all-ones quotient, so no quotient negation then.
  assign w_neg_q_cap = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]) && (divisor != '0);
  assign w_dvd_cap   = w_neg_r_cap ? -dividend : dividend;
  assign w_dvs_cap   = (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
  assign w_quot_fix  = r_neg_q ? -w_q_nxt : w_q_nxt;
  assign w_rem_fix   = r_neg_r ? -w_r_nxt[WIDTH-1:0] : w_r_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_neg_q_cap;
      r_neg_r <= w_neg_r_cap;
    end
  end
`else
  assign w_dvd_cap  = dividend;
  assign w_dvs_cap  = divisor;
  assign w_quot_fix = w_q_nxt;
  assign w_rem_fix  = w_r_nxt[WIDTH-1:0];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_r    <= '0;
      r_d    <= '0;
      r_cnt  <= '0;
      r_dz   <= 1'b0;
      r_quot <= '0;
      r_rem  <= '0;
    end else if (w_accept) begin
      r_q   <= w_dvd_cap;
      r_r   <= '0;
      r_d   <= w_dvs_cap;
      r_cnt <= '0;
      r_dz  <= (divisor == '0);
    end else if (r_state == S_RUN) begin
      r_q   <= w_q_nxt;
      r_r   <= w_r_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quot <= w_quot_fix;
        r_rem  <= w_rem_fix;
      end
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed cases plus random operands against an
// arithmetic reference model; signed cases are included when DIV_SIGNED_EN is defined.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] dividend, divisor;
`ifdef DIV_SIGNED_EN
  logic        is_signed;
`endif
  logic        busy, done, div_zero;
  logic [31:0] quotient, remainder;

  int n_checks = 0;
  int n_pass   = 0;
  logic [64:0] exp_q[$];
  logic [64:0] last_exp;

  div32_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
`ifdef DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // reference model: {div_zero, quotient, remainder}
  function automatic logic [64:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {(b == 32'd0), q, r};
  endfunction

  // driver: called at a negedge, start is accepted on the following posedge
  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic s_eff;
    s_eff = 1'b0;
`ifdef DIV_SIGNED_EN
    is_signed = s;
    s_eff = s;
`endif
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(ref_div(a, b, s_eff));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input int lat0, input string tag);
    int lat;
    int busy_gaps;
    logic [64:0] e;
    lat = lat0;
    busy_gaps = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_gaps++;
      @(negedge clk);
      lat++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'd0;
    last_exp = e;
    if (!done) begin
      check({tag, "_done_seen"}, done, 1'b1);
    end else begin
      check({tag, "_latency"}, lat, 32);
      check({tag, "_busy_steady"}, busy_gaps, 0);
      check({tag, "_busy_off"}, busy, 1'b0);
      check({tag, "_quot"}, quotient, e[63:32]);
      check({tag, "_rem"}, remainder, e[31:0]);
      check({tag, "_dz"}, div_zero, e[64]);
    end
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_held_q"}, quotient, last_exp[63:32]);
    check({tag, "_held_r"}, remainder, last_exp[31:0]);
  endtask

  task automatic count_done(input int cycles, input string tag);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check(tag, pulses, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          mode;

    rst_n = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
`ifdef DIV_SIGNED_EN
    is_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_quot", quotient, 32'd0);
    check("rst_rem", remainder, 32'd0);
    check("rst_dz", div_zero, 1'b0);

    drive_start(32'd100, 32'd7, 1'b0);
    wait_done(0, "d100_7");
    idle_check("d100_7");

    drive_start(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done(0, "dmax_1");
    drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(0, "dmax_max_b2b");
    idle_check("dmax_max");

    drive_start(32'd5, 32'd0, 1'b0);
    wait_done(0, "d5_0");
    drive_start(32'd9, 32'd3, 1'b0);
    wait_done(0, "d9_3_b2b");
    idle_check("d9_3");

    drive_start(32'd3, 32'd10, 1'b0);
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, "ign_start");
    count_done(40, "ign_extra_done");

    drive_start(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_quot", quotient, 32'd0);
    check("midrst_rem", remainder, 32'd0);
    check("midrst_dz", div_zero, 1'b0);
    count_done(40, "midrst_no_done");
    drive_start(32'd1000, 32'd3, 1'b0);
    wait_done(0, "d1000_3");
    idle_check("d1000_3");

`ifdef DIV_SIGNED_EN
    drive_start(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done(0, "s_m7_2");
    drive_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, "s_min_m1");
    drive_start(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done(0, "s_7_m2");
    drive_start(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(0, "u_fff9_2");
    drive_start(32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_done(0, "s_m7_0");
    idle_check("signed_dir");
`endif

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0:       b = $urandom;
        1:       b = $urandom_range(1, 255);
        2:       b = 32'd0;
        default: b = a + $urandom_range(1, 1000);
      endcase
      s = 1'(($urandom_range(0, 1)));
      drive_start(a, b, s);
      wait_done(0, "rand");
      if ($urandom_range(0, 1) == 0) idle_check("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div32_seq.md
Name: div32_seq

Overview:
- Multi-cycle 32-bit restoring divider for the ALU execute stage.
- Each cycle it feeds one trial subtraction of the shifted partial remainder minus the divisor to the datapath subtractor. It uses that subtractor's carry-out (1 = no borrow) to decide each quotient bit.
- Produces quotient and remainder for the div/rem instructions.
- Hands results to the register writeback with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  32  numerator; captured when start is accepted.
- divisor  input  32  denominator; captured when start is accepted.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  32  result; held until the next accepted start.
- remainder  output  32  result; held until the next accepted start.
- div_zero  output  1  divisor was 0 for the current result; held with the results.

Behaviour:
- One clock domain, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, div_zero = 0; quotient, remainder = 0.
  - Reset mid-operation abandons the division.
  - No done pulse is produced for the abandoned division.
- States: IDLE, RUN, DONE.
- IDLE, start=1: capture operands; Q=dividend, R=0 (33-bit internal), D=divisor, cnt=0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, one iteration per cycle:
  - S = {R[31:0], Q[31]} (33 bits).
  - Trial T = S - {0,D}, computed as S + ~{0,D} + 1.
  - If no borrow: R=T and the shifted-in quotient bit is 1. Otherwise R=S and the bit is 0.
  - Q={Q[30:0], bit}; cnt++.
- After the 32nd iteration (cnt=31 at the edge): load quotient=Q, remainder=R[31:0]; busy=0; done=1 for exactly one cycle; state=DONE.
- Latency: start accepted at edge E0 gives done=1 after edge E32, i.e. 32 cycles. The next start may be accepted in the done cycle.
- DONE: done returns to 0 after one cycle.
  - start=1 restarts exactly as from IDLE.
  - Otherwise state=IDLE with results held.
- start while in RUN: ignored. No queuing; captured operands are unchanged.
- divisor=0: the algorithm runs its full 32 cycles unmodified.
  - Result is quotient=0xFFFFFFFF, remainder=dividend, div_zero=1.
- div_zero is computed at capture and cleared at the next accepted start.
- dividend < divisor: quotient=0, remainder=dividend.
- Unsigned arithmetic throughout. No overflow is possible in unsigned mode.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Adds input port is_signed (1 bit), captured with start.
  - If is_signed=1, operands are replaced by their magnitudes at capture.
  - At load, quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0.
  - Divide by zero gives quotient=0xFFFFFFFF, remainder=original dividend.
  - Latency is unchanged (32 cycles). Sign fixup happens in the final load.
- Undefined: no is_signed port; unsigned only; identical to the base behaviour.

Test Plan:
- 100 / 7, start pulse in IDLE -> busy for 32 cycles; done after exactly 32 cycles; quotient=14, remainder=2, div_zero=0.
- 0xFFFFFFFF / 1, then 0xFFFFFFFF / 0xFFFFFFFF -> (0xFFFFFFFF, 0), then (1, 0). Second start is issued in the done cycle; back-to-back latency stays 32.
- 5 / 0 -> quotient=0xFFFFFFFF, remainder=5, div_zero=1. A following 9 / 3 gives 3, 0 with div_zero=0.
- 3 / 10 with start re-pulsed (operands 50 / 5) at cycle 10 of RUN -> second start ignored; result 0, 3; only one done pulse.
- Start 1000 / 3, drive rst_n=0 at cycle 15 for one cycle -> all outputs 0, no done. A subsequent 1000 / 3 gives 333, 1.
- DIV_SIGNED_EN defined:
  - -7 / 2 -> 0xFFFFFFFD, 0xFFFFFFFF.
  - 0x80000000 / -1 -> 0x80000000, 0.
  - 7 / -2 -> 0xFFFFFFFD, 1.
  - With is_signed=0, 0xFFFFFFF9 / 2 -> 0x7FFFFFFC, 1.
